hash_msg_feeder: RTL and testbench

- Upstream feeder for the 32-bit S-box hash core.
- Accepts a declared message length from the host, then accepts a byte stream through a valid/ready handshake and buffers it in a small FIFO.
- Drives the core's message/M_valid/counter inputs at one byte per cycle.
- Captures the core's digest on hash_ready and holds it for the host until acknowledged.

---
 rtl/hash_msg_feeder.sv | 177 +++++++++++++++++
 tb/tb_hash_msg_feeder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_msg_feeder.sv
// Upstream feeder for the 32-bit S-box hash core: takes a declared length, buffers
// the host byte stream in a small FIFO and replays it to the core at one byte/cycle.
// Latency: a byte accepted at edge k is popped at edge k+1 and seen with M_valid after it.
// Backpressure: in_ready drops when the FIFO is full or all declared bytes are in;
// the core side never stalls, and the digest is held until digest_ack.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   len_in/len_valid/len_ready     declared message length handshake (IDLE only)
//   in_data/in_valid/in_last/in_ready   host byte stream (in_last checked only)
//   message/M_valid/counter/msg_start   hash core drive
//   hash_ready/digest              core digest strobe
//   digest_out/digest_valid/digest_ack  latched digest to host
//   frame_err, busy                sticky framing error, not-idle status
module hash_msg_feeder #(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LEN_W-1:0] len_in,
    input  logic             len_valid,
    output logic             len_ready,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [7:0]       message,
    output logic             M_valid,
    output logic [LEN_W-1:0] counter,
    output logic             msg_start,
    input  logic             hash_ready,
    input  logic [31:0]      digest,
    output logic [31:0]      digest_out,
    output logic             digest_valid,
    input  logic             digest_ack,
    output logic             frame_err,
    output logic             busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_DIGEST, HOLD} state_t;

    state_t           state_q, state_d;
    logic [7:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LEN_W-1:0] counter_q, counter_d;
    logic [LEN_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [LEN_W-1:0] tx_cnt_q, tx_cnt_d;
    logic             frame_err_q, frame_err_d;
    logic [31:0]      digest_q, digest_d;
    logic             digest_valid_q, digest_valid_d;
    logic [7:0]       message_q;
    logic             m_valid_q;
    logic             msg_start_q;

    logic fifo_empty, fifo_full, len_ok, push, pop, last_pop, rx_final;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign len_ready = (state_q == IDLE);
    assign in_ready  = (state_q == STREAM) && !fifo_full && (rx_cnt_q < counter_q);
    assign busy      = (state_q != IDLE);

    assign len_ok   = len_ready && len_valid && (len_in != '0);
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == STREAM) && !fifo_empty;
    assign rx_final = ((rx_cnt_q + LEN_W'(1)) == counter_q);
    assign last_pop = pop && ((tx_cnt_q + LEN_W'(1)) == counter_q);

    always_comb begin
        state_d        = state_q;
        counter_d      = counter_q;
        rx_cnt_d       = rx_cnt_q;
        tx_cnt_d       = tx_cnt_q;
        frame_err_d    = frame_err_q;
        digest_d       = digest_q;
        digest_valid_d = digest_valid_q;
        case (state_q)
            IDLE: begin
                if (len_valid) begin
                    if (len_in == '0) begin
                        frame_err_d = 1'b1;
                    end else begin
                        counter_d   = len_in;
                        rx_cnt_d    = '0;
                        tx_cnt_d    = '0;
                        frame_err_d = 1'b0;
                        state_d     = STREAM;
                    end
                end
            end
            STREAM: begin
                if (push) begin
                    rx_cnt_d = rx_cnt_q + LEN_W'(1);
                    // in_last must coincide exactly with the final declared byte.
                    if (in_last != rx_final) begin
                        frame_err_d = 1'b1;
                    end
                end
                if (pop) begin
                    tx_cnt_d = tx_cnt_q + LEN_W'(1);
                end
                if (last_pop) begin
                    state_d = WAIT_DIGEST;
                end
            end
            WAIT_DIGEST: begin
                if (hash_ready) begin
                    digest_d       = digest;
                    digest_valid_d = 1'b1;
                    state_d        = HOLD;
                end
            end
            HOLD: begin
                if (digest_ack) begin
                    digest_valid_d = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            counter_q      <= '0;
            rx_cnt_q       <= '0;
            tx_cnt_q       <= '0;
            frame_err_q    <= 1'b0;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
            message_q      <= '0;
            m_valid_q      <= 1'b0;
            msg_start_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            counter_q      <= counter_d;
            rx_cnt_q       <= rx_cnt_d;
            tx_cnt_q       <= tx_cnt_d;
            frame_err_q    <= frame_err_d;
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
            msg_start_q    <= len_ok;
            m_valid_q      <= pop;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + PW'(1);
                message_q <= fifo_mem_q[rd_ptr_q[AW-1:0]];
            end
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    assign message      = message_q;
    assign M_valid      = m_valid_q;
    assign counter      = counter_q;
    assign msg_start    = msg_start_q;
    assign digest_out   = digest_q;
    assign digest_valid = digest_valid_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_hash_msg_feeder.sv
module tb_hash_msg_feeder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] len_in = '0;
    logic        len_valid = 1'b0;
    logic        len_ready;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [7:0]  message;
    logic        M_valid;
    logic [63:0] counter;
    logic        msg_start;
    logic        hash_ready = 1'b0;
    logic [31:0] digest = '0;
    logic [31:0] digest_out;
    logic        digest_valid;
    logic        digest_ack = 1'b0;
    logic        frame_err;
    logic        busy;

    hash_msg_feeder #(.FIFO_DEPTH(8), .LEN_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .len_in(len_in), .len_valid(len_valid), .len_ready(len_ready),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .message(message), .M_valid(M_valid), .counter(counter), .msg_start(msg_start),
        .hash_ready(hash_ready), .digest(digest),
        .digest_out(digest_out), .digest_valid(digest_valid), .digest_ack(digest_ack),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phases of a message transaction, a queue of bytes with the
    // cycle at which each must appear on the core side, and the framing rule.
    typedef struct { int cyc; logic [7:0] b; } exp_t;
    exp_t        exp_q[$];
    int          cyc = 0;
    int          ph = 0;           // 0 idle, 1 streaming, 2 awaiting digest, 3 holding
    int          m_len = 0, m_rx = 0, m_tx = 0;
    logic        m_ferr = 1'b0, m_ms = 1'b0, m_dv = 1'b0;
    logic [31:0] m_dout = '0;
    int          mv_cnt = 0, ms_cnt = 0;
    bit          fired = 1'b0;

    // One clock: observe and compare at the falling edge, then advance the model
    // by what the upcoming rising edge will do; return just after that edge.
    task automatic tick();
        bit exp_mv, exp_ir;
        @(negedge clk);
        cyc++;
        fired = in_valid && in_ready;
        if (!rst_n) begin
            exp_q.delete();
            ph = 0; m_len = 0; m_rx = 0; m_tx = 0;
            m_ferr = 1'b0; m_ms = 1'b0; m_dv = 1'b0; m_dout = '0;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
            exp_mv = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            chk("m_valid", 64'(M_valid), 64'(exp_mv));
            if (M_valid) mv_cnt++;
            if (msg_start) ms_cnt++;
            if (exp_mv) begin
                chk("message", 64'(message), 64'(exp_q[0].b));
                void'(exp_q.pop_front());
                m_tx++;
                if (m_tx == m_len) ph = 2;
            end
            exp_ir = (ph == 1) && (m_rx < m_len);
            chk("in_ready", 64'(in_ready), 64'(exp_ir));
            chk("len_ready", 64'(len_ready), 64'(ph == 0));
            chk("busy", 64'(busy), 64'(ph != 0));
            chk("frame_err", 64'(frame_err), 64'(m_ferr));
            chk("counter", counter, 64'(m_len));
            chk("msg_start", 64'(msg_start), 64'(m_ms));
            chk("digest_valid", 64'(digest_valid), 64'(m_dv));
            chk("digest_out", 64'(digest_out), 64'(m_dout));
            m_ms = 1'b0;
            if (ph == 0 && len_valid) begin
                if (len_in == 0) m_ferr = 1'b1;
                else begin
                    m_len = int'(len_in); m_rx = 0; m_tx = 0;
                    m_ferr = 1'b0; m_ms = 1'b1; ph = 1;
                end
            end else if (ph == 1 && in_valid && exp_ir) begin
                exp_q.push_back('{cyc + 2, in_data});
                m_rx++;
                if (in_last != (m_rx == m_len)) m_ferr = 1'b1;
            end else if (ph == 2 && hash_ready) begin
                m_dout = digest; m_dv = 1'b1; ph = 3;
            end else if (ph == 3 && digest_ack) begin
                m_dv = 1'b0; ph = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_message"}, 64'(message), 64'(0));
        chk({tag, "_m_valid"}, 64'(M_valid), 64'(0));
        chk({tag, "_counter"}, counter, 64'(0));
        chk({tag, "_msg_start"}, 64'(msg_start), 64'(0));
        chk({tag, "_digest_out"}, 64'(digest_out), 64'(0));
        chk({tag, "_digest_valid"}, 64'(digest_valid), 64'(0));
        chk({tag, "_frame_err"}, 64'(frame_err), 64'(0));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        chk({tag, "_len_ready"}, 64'(len_ready), 64'(1));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    // Offer len, then push nbytes bytes; in_last goes on byte index last_idx.
    task automatic send_msg(input int len, input int last_idx, input logic [7:0] base,
                            input bit gaps, input bit rnd, input int nbytes, output int stalls);
        int  i;
        bit  go;
        stalls = 0; mv_cnt = 0; ms_cnt = 0;
        len_in = 64'(len); len_valid = 1'b1;
        tick();
        len_valid = 1'b0;
        i = 0;
        for (int t = 0; t < 2000 && i < nbytes; t++) begin
            go = !gaps || ($urandom_range(2) != 0);
            in_valid = go;
            in_data = rnd ? 8'($urandom) : base + 8'(i);
            in_last = (i == last_idx);
            hash_ready = gaps && ($urandom_range(3) == 0);
            digest = $urandom;
            tick();
            if (fired) i++;
            else if (go) stalls++;
        end
        in_valid = 1'b0; in_last = 1'b0; hash_ready = 1'b0;
        chk("bytes_sent", 64'(i), 64'(nbytes));
    endtask

    task automatic drain_and_digest(input int len, input bit exp_ferr, input logic [31:0] dig);
        int t;
        t = 0;
        while (mv_cnt < len && t < 200) begin tick(); t++; end
        chk("drain_timeout", 64'(t < 200), 64'(1));
        tick(); tick();
        chk("mv_count", 64'(mv_cnt), 64'(len));
        chk("msg_start_count", 64'(ms_cnt), 64'(1));
        chk("frame_err_end", 64'(frame_err), 64'(exp_ferr));
        chk("wait_busy", 64'(busy), 64'(1));
        hash_ready = 1'b1; digest = dig;
        tick();
        hash_ready = 1'b0; digest = ~dig;
        tick(); tick();
        chk("digest_held", 64'(digest_out), 64'(dig));
        chk("digest_valid_held", 64'(digest_valid), 64'(1));
        chk("len_ready_hold", 64'(len_ready), 64'(0));
        digest_ack = 1'b1;
        tick();
        digest_ack = 1'b0;
        tick();
        chk("len_ready_after_ack", 64'(len_ready), 64'(1));
        chk("digest_valid_after_ack", 64'(digest_valid), 64'(0));
    endtask

    typedef struct {
        int          len;
        int          last_idx;
        logic [7:0]  base;
        bit          gaps;
        bit          rnd;
        bit          exp_ferr;
        bit          no_stall;
        logic [31:0] dig;
    } vec_t;

    vec_t vt[6];
    int   st;

    initial begin
        vt[0] = '{3,  2,  8'h61, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
        vt[1] = '{20, 19, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678};
        vt[2] = '{4,  1,  8'h30, 1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D};
        vt[3] = '{5,  -1, 8'h40, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0BADC0DE};
        vt[4] = '{7,  6,  8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5};
        vt[5] = '{1,  0,  8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000001};

        #1 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        tick();
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 6; k++) begin
            send_msg(vt[k].len, vt[k].last_idx, vt[k].base, vt[k].gaps, vt[k].rnd, vt[k].len, st);
            if (vt[k].no_stall) chk("no_stall", 64'(st), 64'(0));
            drain_and_digest(vt[k].len, vt[k].exp_ferr, vt[k].dig);
        end

        // Zero length: error flagged, nothing starts.
        mv_cnt = 0; ms_cnt = 0;
        len_in = '0; len_valid = 1'b1;
        tick();
        len_valid = 1'b0;
        repeat (4) tick();
        chk("len0_frame_err", 64'(frame_err), 64'(1));
        chk("len0_busy", 64'(busy), 64'(0));
        chk("len0_msg_start", 64'(ms_cnt), 64'(0));
        chk("len0_m_valid", 64'(mv_cnt), 64'(0));

        // Randomised messages; in_last sometimes misplaced or missing.
        for (int k = 0; k < 6; k++) begin
            int len, li;
            len = int'($urandom_range(12, 1));
            li = ($urandom_range(3) == 0) ? int'($urandom_range(len, 0)) : len - 1;
            send_msg(len, li, 8'h00, 1'b1, 1'b1, len, st);
            drain_and_digest(len, li != len - 1, $urandom);
        end

        // Reset in the middle of a message (after 2 of 5 bytes, framing already bad).
        send_msg(5, 0, 8'h10, 1'b0, 1'b0, 2, st);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("mid");
        tick();
        rst_n = 1'b1;
        tick();
        send_msg(1, 0, 8'h5A, 1'b0, 1'b0, 1, st);
        drain_and_digest(1, 1'b0, 32'h600DF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
